xeng_acc_reader: RTL

Consumer end of the X-engine accumulator chain. It takes complex accumulation words from the tail of the cmac shift register, qualified by the chain's valid strobe. It then splits each word into real and imaginary parts, resizes them to the output width and tags them with a baseline index and a last-of-dump flag. Results go into a small FIFO and drain through a valid/ready port towards the vector-accumulator/packetiser.

---
 rtl/xeng_acc_reader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/xeng_acc_reader.sv
// Accumulator-chain reader: splits complex words, resizes each part, tags baselines, buffers in a FWFT FIFO.
// Optional build macro XENG_ACC_READER_SAT_EN selects clamping instead of wrap when narrowing.
module xeng_acc_reader #(
   parameter int BITWIDTH            = 4,
   parameter int P_FACTOR_BITS       = 3,
   parameter int SERIAL_ACC_LEN_BITS = 7,
   parameter int OUT_BITS            = 16,
   parameter int N_BASELINES         = 8,
   parameter int FIFO_DEPTH_BITS     = 4,
   localparam int ACC_IN_BITS = 2*BITWIDTH + 1 + P_FACTOR_BITS + SERIAL_ACC_LEN_BITS,
   localparam int BL_W        = $clog2(N_BASELINES)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          sync,
   input  logic [2*ACC_IN_BITS-1:0]      acc_in,
   input  logic                          valid_in,
   output logic signed [OUT_BITS-1:0]    out_re,
   output logic signed [OUT_BITS-1:0]    out_im,
   output logic [BL_W-1:0]               out_bl,
   output logic                          out_last,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          overflow,
   output logic [FIFO_DEPTH_BITS:0]      fifo_level
);

   localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
   localparam logic [BL_W-1:0] BL_LAST = BL_W'(N_BASELINES - 1);
   localparam logic [FIFO_DEPTH_BITS:0] LVL_FULL = (FIFO_DEPTH_BITS+1)'(DEPTH);

`ifdef XENG_ACC_READER_SAT_EN
   localparam int EXT_W = ACC_IN_BITS + OUT_BITS;
   localparam logic signed [EXT_W-1:0] SAT_MAX = {{(ACC_IN_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

   // Clamp never triggers when the output is at least as wide as the input, leaving a plain sign-extend.
   function automatic logic signed [OUT_BITS-1:0] resize_part(input logic signed [ACC_IN_BITS-1:0] x);
      logic signed [EXT_W-1:0] ext;
      ext = {{OUT_BITS{x[ACC_IN_BITS-1]}}, x};
      if (ext > SAT_MAX) return SAT_MAX[OUT_BITS-1:0];
      if (ext < SAT_MIN) return SAT_MIN[OUT_BITS-1:0];
      return ext[OUT_BITS-1:0];
   endfunction
`else
   function automatic logic signed [OUT_BITS-1:0] resize_part(input logic signed [ACC_IN_BITS-1:0] x);
      return OUT_BITS'(x);
   endfunction
`endif

   logic [BL_W-1:0]               bl_cnt_q, bl_cnt_d, bl_idx;
   logic                          vld_p1_q, vld_p1_d;
   logic signed [OUT_BITS-1:0]    re_p1_q, re_p1_d, im_p1_q, im_p1_d;
   logic [BL_W-1:0]               bl_p1_q, bl_p1_d;

   logic [FIFO_DEPTH_BITS-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FIFO_DEPTH_BITS:0]      level_q, level_d;
   logic                          overflow_q, overflow_d;
   logic                          push, pop, drop, head_vld;

   logic signed [OUT_BITS-1:0]    re_mem [DEPTH];
   logic signed [OUT_BITS-1:0]    im_mem [DEPTH];
   logic [BL_W-1:0]               bl_mem [DEPTH];

   // ---- stage 1: split, resize, tag ----
   always_comb begin
      bl_idx   = sync ? '0 : bl_cnt_q;
      bl_cnt_d = bl_cnt_q;
      if (valid_in) begin
         bl_cnt_d = (bl_idx == BL_LAST) ? '0 : bl_idx + 1'b1;
      end else if (sync) begin
         bl_cnt_d = '0;
      end
      vld_p1_d = valid_in;
      re_p1_d  = resize_part(acc_in[2*ACC_IN_BITS-1:ACC_IN_BITS]);
      im_p1_d  = resize_part(acc_in[ACC_IN_BITS-1:0]);
      bl_p1_d  = bl_idx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bl_cnt_q <= '0;
         vld_p1_q <= 1'b0;
      end else begin
         bl_cnt_q <= bl_cnt_d;
         vld_p1_q <= vld_p1_d;
      end
   end

   always_ff @(posedge clk) begin
      if (valid_in) begin
         re_p1_q <= re_p1_d;
         im_p1_q <= im_p1_d;
         bl_p1_q <= bl_p1_d;
      end
   end

   // ---- stage 2: FIFO write / read bookkeeping ----
   always_comb begin
      head_vld   = (level_q != '0);
      pop        = head_vld && out_ready;
      push       = vld_p1_q && ((level_q != LVL_FULL) || pop);
      drop       = vld_p1_q && !push;
      wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_d    = level_q;
      if (push && !pop) begin
         level_d = level_q + 1'b1;
      end else if (pop && !push) begin
         level_d = level_q - 1'b1;
      end
      // A drop on the same edge as sync keeps the flag raised.
      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
      end else if (sync) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         re_mem[wr_ptr_q] <= re_p1_q;
         im_mem[wr_ptr_q] <= im_p1_q;
         bl_mem[wr_ptr_q] <= bl_p1_q;
      end
   end

   // Head is masked so that reset and empty both present all-zero outputs.
   always_comb begin
      out_valid  = head_vld;
      out_re     = head_vld ? re_mem[rd_ptr_q] : '0;
      out_im     = head_vld ? im_mem[rd_ptr_q] : '0;
      out_bl     = head_vld ? bl_mem[rd_ptr_q] : '0;
      out_last   = head_vld && (bl_mem[rd_ptr_q] == BL_LAST);
      overflow   = overflow_q;
      fifo_level = level_q;
   end

endmodule
